alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Registered issue stage directly upstream of the arithmetic logic unity. It accepts decoded instructions from the decoder through a valid/ready handshake and resolves the second operand (register or extended immediate). It then presents `op`, `shamt`, `data_1` and `data_2` to the ALU from flops. A 2-entry skid buffer decouples decoder stalls from ALU-side stalls, and an optional write-back forwarding path patches stale register operands.

## Interface
- `DATA_WIDTH`, 32, operand and result width.
- `OP_WIDTH`, 5, ALU op-code and shamt width.
- `REG_ADDR_WIDTH`, 5, register index width.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: decoder presents an instruction.
- `in_ready` out 1: stage can accept; registered.
- `in_op` in OP_WIDTH: ALU op-code.
- `in_shamt` in OP_WIDTH: shift amount.
- `in_rs_addr`, `in_rt_addr` in REG_ADDR_WIDTH: source register indices.
- `in_rs_data`, `in_rt_data` in DATA_WIDTH: register-file read data.
- `in_imm` in 16: immediate field.
- `in_use_imm` in 1: data_2 comes from the immediate.
- `in_rd_addr` in REG_ADDR_WIDTH: destination index, carried along.
- `fwd_valid` in 1: write-back is writing a register this cycle.
- `fwd_addr` in REG_ADDR_WIDTH: write-back register index.
- `fwd_data` in DATA_WIDTH: write-back data.
- `out_valid` out 1: ALU inputs are valid.
- `out_ready` in 1: consumer accepts the ALU result this cycle.
- `op`, `shamt` out OP_WIDTH: to the ALU.
- `data_1`, `data_2` out DATA_WIDTH: to the ALU.
- `out_rd_addr` out REG_ADDR_WIDTH: destination index for write-back.

## Operation
- Storage: `main` entry drives the outputs. `skid` entry holds one overflow instruction. Each entry holds op, shamt, rd, data_1, data_2, rs_addr, rt_addr and a flag `rt_is_reg` (= !in_use_imm).
- Immediate extension when `in_use_imm`=1:
  - Zero-extended for op 01010, 01011, 01100 (and/or/xor).
  - Sign-extended for all other ops.
- Accept = `in_valid && in_ready`. Drain = `out_valid && out_ready`.
- Entry movement:
  - Accept while main is empty, or main draining with skid empty: the instruction goes to main.
  - Accept while main is held and not draining: the instruction goes to skid.
  - Drain with skid full: skid moves to main. A simultaneous accept is impossible because `in_ready`=0.
- `in_ready` = !skid_valid, registered.
- Op codes are passed through unchecked. Undefined codes reach the ALU, which outputs 0.
- States: EMPTY (main invalid), ONE (main valid), FULL (main and skid valid).
  - EMPTY→ONE on accept.
  - ONE→EMPTY on drain without accept.
  - ONE→FULL on accept without drain.
  - ONE→ONE on accept with drain.
  - FULL→ONE on drain.

## Timing
- Reset values:
  - `out_valid`=0, `in_ready`=1, state EMPTY.
  - `op`, `shamt`, `data_1`, `data_2`, `out_rd_addr` = 0.
- Latency: accept in cycle N gives `out_valid`=1 in N+1 with the registered operands.
- Throughput: one instruction per cycle while `out_ready`=1.
- Backpressure: outputs hold stable while `out_valid && !out_ready`.
- Reset asserted mid-operation: both entries are discarded immediately and outputs return to reset values.

## Configuration
- Macro `ALU_OPERAND_FORWARD_EN`.
- When defined, forwarding applies whenever `fwd_valid`=1 and the register address ≠ 0:
  - Capture: if `fwd_addr`=`in_rs_addr`, data_1 captures `fwd_data`. If `fwd_addr`=`in_rt_addr` and `rt_is_reg`, data_2 captures `fwd_data`.
  - Held entries: each cycle, main and skid entries whose rs/rt match `fwd_addr` overwrite the corresponding data field. Immediates are never overwritten.
- When undefined, the `fwd_*` ports exist but are ignored, and rs/rt addresses are not stored.

## Structure
- Shared package `bm_core_pkg`:
  - ALU op-code constants (OP_ADD=5'b00000 … OP_CONCAT=5'b10000).
  - Struct typedef for an operand-stage entry.
- One sub-module `imm_extend` (16→DATA_WIDTH, sign/zero select from op). The rest is flat.

## Test plan
- Reset, then one accept of op=00000, rs_data=5, rt_data=7, in_use_imm=0, out_ready=1: next cycle `out_valid`=1, data_1=5, data_2=7; the cycle after, `out_valid`=0.
- in_use_imm=1, in_imm=16'hFFFF, op=00000 → data_2=32'hFFFFFFFF. Same imm with op=01010 → data_2=32'h0000FFFF.
- out_ready=0 with 3 back-to-back accepts attempted:
  - The first two are accepted and `in_ready` falls to 0 after the second; the third waits.
  - Outputs stay on instruction 1.
  - Raising out_ready delivers 1, 2, 3 in order, with no loss or duplication.
- With `ALU_OPERAND_FORWARD_EN`:
  - Capture: in_rs_addr=3, fwd_valid=1, fwd_addr=3, fwd_data=42 → data_1=42.
  - Held entry: an entry with rt_addr=4 is held, then fwd_addr=4, fwd_data=9 → data_2=9.
  - fwd_addr=0 → no substitution.
- rst_n pulsed low while FULL: `out_valid`=0 and `in_ready`=1 in the same cycle; after release no stale instruction emerges.
- Simultaneous accept and drain in ONE for 8 cycles: `out_valid` stays 1 and a new instruction appears on the outputs every cycle.

Source files
------------

// File: rtl/bm_core_pkg.sv
// Shared core definitions: ALU op-codes, operand-stage entry and stage states.
package bm_core_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned REG_W  = 5;

  localparam logic [OP_W-1:0] OP_ADD    = 5'b00000;
  localparam logic [OP_W-1:0] OP_SUB    = 5'b00001;
  localparam logic [OP_W-1:0] OP_ADDU   = 5'b00010;
  localparam logic [OP_W-1:0] OP_SUBU   = 5'b00011;
  localparam logic [OP_W-1:0] OP_SLT    = 5'b00100;
  localparam logic [OP_W-1:0] OP_SLTU   = 5'b00101;
  localparam logic [OP_W-1:0] OP_SLL    = 5'b00110;
  localparam logic [OP_W-1:0] OP_SRL    = 5'b00111;
  localparam logic [OP_W-1:0] OP_SRA    = 5'b01000;
  localparam logic [OP_W-1:0] OP_NOR    = 5'b01001;
  localparam logic [OP_W-1:0] OP_AND    = 5'b01010;
  localparam logic [OP_W-1:0] OP_OR     = 5'b01011;
  localparam logic [OP_W-1:0] OP_XOR    = 5'b01100;
  localparam logic [OP_W-1:0] OP_LUI    = 5'b01101;
  localparam logic [OP_W-1:0] OP_SLLV   = 5'b01110;
  localparam logic [OP_W-1:0] OP_SRLV   = 5'b01111;
  localparam logic [OP_W-1:0] OP_CONCAT = 5'b10000;

  // One buffered instruction with its resolved operands.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [OP_W-1:0]   shamt;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data_1;
    logic [DATA_W-1:0] data_2;
    logic [REG_W-1:0]  rs_addr;
    logic [REG_W-1:0]  rt_addr;
    logic              rt_is_reg;
  } opnd_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } stage_state_t;

  // Logical ops take a zero-extended immediate; everything else sign-extends.
  function automatic logic imm_is_logical(input logic [OP_W-1:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/alu_operand_stage_imm_extend.sv
// Immediate extender: 16-bit immediate to DATA_WIDTH, zero or sign by op-code.
module imm_extend
  import bm_core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 5
) (
  input  logic [15:0]           imm,
  input  logic [OP_WIDTH-1:0]   op,
  output logic [DATA_WIDTH-1:0] ext
);

  // Select zero- or sign-extension of the immediate.
  always_comb begin
    ext = {{(DATA_WIDTH-16){imm[15]}}, imm};
    if (imm_is_logical(op)) begin
      ext = {{(DATA_WIDTH-16){1'b0}}, imm};
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered ALU issue stage with a 2-entry skid buffer (main + skid).
// Optional write-back forwarding is enabled by defining ALU_OPERAND_FORWARD_EN.
module alu_operand_stage
  import bm_core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned OP_WIDTH       = 5,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OP_WIDTH-1:0]       in_op,
  input  logic [OP_WIDTH-1:0]       in_shamt,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rt_addr,
  input  logic [DATA_WIDTH-1:0]     in_rs_data,
  input  logic [DATA_WIDTH-1:0]     in_rt_data,
  input  logic [15:0]               in_imm,
  input  logic                      in_use_imm,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
  input  logic                      fwd_valid,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_addr,
  input  logic [DATA_WIDTH-1:0]     fwd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OP_WIDTH-1:0]       op,
  output logic [OP_WIDTH-1:0]       shamt,
  output logic [DATA_WIDTH-1:0]     data_1,
  output logic [DATA_WIDTH-1:0]     data_2,
  output logic [REG_ADDR_WIDTH-1:0] out_rd_addr
);

  stage_state_t state, state_n;
  opnd_entry_t  main_q, main_n, skid_q, skid_n, incoming;
  logic         in_ready_n;
  logic         accept, drain;
  logic [DATA_WIDTH-1:0] imm_ext;

  imm_extend #(
    .DATA_WIDTH (DATA_WIDTH),
    .OP_WIDTH   (OP_WIDTH)
  ) u_imm_extend (
    .imm (in_imm),
    .op  (in_op),
    .ext (imm_ext)
  );

  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  assign out_valid = (state != ST_EMPTY);

  assign op          = main_q.op;
  assign shamt       = main_q.shamt;
  assign data_1      = main_q.data_1;
  assign data_2      = main_q.data_2;
  assign out_rd_addr = main_q.rd;

`ifdef ALU_OPERAND_FORWARD_EN
  logic fwd_hit;
  assign fwd_hit = fwd_valid && (fwd_addr != '0);

  // Refresh a held entry's register operands from the write-back port.
  function automatic opnd_entry_t patch(input opnd_entry_t e, input logic hit,
                                        input logic [REG_W-1:0] a, input logic [DATA_W-1:0] d);
    opnd_entry_t r;
    r = e;
    if (hit && (e.rs_addr == a)) r.data_1 = d;
    if (hit && e.rt_is_reg && (e.rt_addr == a)) r.data_2 = d;
    return r;
  endfunction

  // Build the incoming entry, substituting write-back data for stale register reads.
  always_comb begin
    incoming.op        = in_op;
    incoming.shamt     = in_shamt;
    incoming.rd        = in_rd_addr;
    incoming.rs_addr   = in_rs_addr;
    incoming.rt_addr   = in_rt_addr;
    incoming.rt_is_reg = !in_use_imm;
    incoming.data_1    = (fwd_hit && (fwd_addr == in_rs_addr)) ? fwd_data : in_rs_data;
    incoming.data_2    = in_use_imm ? imm_ext :
                         ((fwd_hit && (fwd_addr == in_rt_addr)) ? fwd_data : in_rt_data);
  end
`else
  function automatic opnd_entry_t patch(input opnd_entry_t e, input logic hit,
                                        input logic [REG_W-1:0] a, input logic [DATA_W-1:0] d);
    return e;
  endfunction

  logic unused_fwd;
  assign unused_fwd = ^{fwd_valid, fwd_addr, fwd_data, in_rs_addr, in_rt_addr,
                        main_q.rs_addr, main_q.rt_addr, main_q.rt_is_reg};

  // Build the incoming entry; register addresses are not kept without forwarding.
  always_comb begin
    incoming.op        = in_op;
    incoming.shamt     = in_shamt;
    incoming.rd        = in_rd_addr;
    incoming.rs_addr   = '0;
    incoming.rt_addr   = '0;
    incoming.rt_is_reg = !in_use_imm;
    incoming.data_1    = in_rs_data;
    incoming.data_2    = in_use_imm ? imm_ext : in_rt_data;
  end
`endif

  // Occupancy FSM and entry movement between input, skid and main.
  always_comb begin
    state_n = state;
    main_n  = patch(main_q, fwd_valid && (fwd_addr != '0), fwd_addr, fwd_data);
    skid_n  = patch(skid_q, fwd_valid && (fwd_addr != '0), fwd_addr, fwd_data);
    unique case (state)
      ST_EMPTY: begin
        if (accept) begin
          main_n  = incoming;
          state_n = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          main_n = incoming;
        end else if (accept) begin
          skid_n  = incoming;
          state_n = ST_FULL;
        end else if (drain) begin
          state_n = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the skid-to-main move can occur
        if (drain) begin
          main_n  = skid_n;
          state_n = ST_ONE;
        end
      end
      default: state_n = ST_EMPTY;
    endcase
    in_ready_n = (state_n != ST_FULL);
  end

  // State, entries and registered in_ready; reset discards both entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      in_ready <= 1'b1;
    end else begin
      state    <= state_n;
      main_q   <= main_n;
      skid_q   <= skid_n;
      in_ready <= in_ready_n;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: queue-based occupancy model plus
// directed vectors. Forwarding cases build when ALU_OPERAND_FORWARD_EN is defined.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  in_op, in_shamt, in_rs_addr, in_rt_addr, in_rd_addr;
  logic [31:0] in_rs_data, in_rt_data;
  logic [15:0] in_imm;
  logic        in_use_imm;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic        out_valid, out_ready;
  logic [4:0]  op, shamt, out_rd_addr;
  logic [31:0] data_1, data_2;

  alu_operand_stage #(
    .DATA_WIDTH     (32),
    .OP_WIDTH       (5),
    .REG_ADDR_WIDTH (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_shamt    (in_shamt),
    .in_rs_addr  (in_rs_addr),
    .in_rt_addr  (in_rt_addr),
    .in_rs_data  (in_rs_data),
    .in_rt_data  (in_rt_data),
    .in_imm      (in_imm),
    .in_use_imm  (in_use_imm),
    .in_rd_addr  (in_rd_addr),
    .fwd_valid   (fwd_valid),
    .fwd_addr    (fwd_addr),
    .fwd_data    (fwd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .op          (op),
    .shamt       (shamt),
    .data_1      (data_1),
    .data_2      (data_2),
    .out_rd_addr (out_rd_addr)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endfunction

  // Model: the stage is an in-order queue of at most two instructions.
  typedef struct {
    logic [4:0]  op, shamt, rd, rs, rt;
    logic [31:0] d1, d2;
    bit          is_reg;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  bit   m_acc, m_drn;

  function automatic logic [31:0] model_ext(logic [15:0] imm, logic [4:0] o);
    if (o == 5'd10 || o == 5'd11 || o == 5'd12) return 32'(imm);
    return 32'($signed(imm));
  endfunction

  always @(negedge rst_n) q.delete();

  always @(posedge clk) begin
    if (rst_n) begin
      m_acc = in_valid && (q.size() < 2);
      m_drn = (q.size() != 0) && out_ready;
`ifdef ALU_OPERAND_FORWARD_EN
      if (fwd_valid && fwd_addr != 5'd0) begin
        for (int i = 0; i < q.size(); i++) begin
          if (q[i].rs == fwd_addr) q[i].d1 = fwd_data;
          if (q[i].is_reg && q[i].rt == fwd_addr) q[i].d2 = fwd_data;
        end
      end
`endif
      if (m_drn) void'(q.pop_front());
      if (m_acc) begin
        m_e.op     = in_op;
        m_e.shamt  = in_shamt;
        m_e.rd     = in_rd_addr;
        m_e.rs     = in_rs_addr;
        m_e.rt     = in_rt_addr;
        m_e.is_reg = !in_use_imm;
        m_e.d1     = in_rs_data;
        m_e.d2     = in_use_imm ? model_ext(in_imm, in_op) : in_rt_data;
`ifdef ALU_OPERAND_FORWARD_EN
        if (fwd_valid && fwd_addr != 5'd0) begin
          if (fwd_addr == in_rs_addr) m_e.d1 = fwd_data;
          if (!in_use_imm && fwd_addr == in_rt_addr) m_e.d2 = fwd_data;
        end
`endif
        q.push_back(m_e);
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    check("out_valid", out_valid, q.size() != 0);
    check("in_ready", in_ready, q.size() < 2);
    if (q.size() != 0)
      check("payload", {op, shamt, out_rd_addr, data_1, data_2},
            {q[0].op, q[0].shamt, q[0].rd, q[0].d1, q[0].d2});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] o, input logic [4:0] sh, input logic [4:0] rd,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic [15:0] imm, input logic use_imm);
    in_valid   = 1'b1;
    in_op      = o;
    in_shamt   = sh;
    in_rd_addr = rd;
    in_rs_addr = rs;
    in_rt_addr = rt;
    in_rs_data = rsd;
    in_rt_data = rtd;
    in_imm     = imm;
    in_use_imm = use_imm;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_op = '0; in_shamt = '0; in_rs_addr = '0; in_rt_addr = '0;
    in_rd_addr = '0; in_rs_data = '0; in_rt_data = '0; in_imm = '0; in_use_imm = 1'b0;
    fwd_valid = 1'b0; fwd_addr = '0; fwd_data = '0;
    out_ready = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_outputs", {op, shamt, data_1, data_2, out_rd_addr}, '0);

    // Single register-register instruction
    out_ready = 1'b1;
    drive(5'b00000, 5'd0, 5'd1, 5'd1, 5'd2, 32'd5, 32'd7, 16'h0, 1'b0);
    cyc(); idle();
    check("t1_valid", out_valid, 1'b1);
    check("t1_data_1", data_1, 32'd5);
    check("t1_data_2", data_2, 32'd7);
    cyc();
    check("t1_empty", out_valid, 1'b0);

    // Immediate extension: sign for add, zero for and
    drive(5'b00000, 5'd0, 5'd2, 5'd1, 5'd2, 32'd1, 32'd2, 16'hFFFF, 1'b1);
    cyc();
    check("imm_sign", data_2, 32'hFFFFFFFF);
    drive(5'b01010, 5'd0, 5'd2, 5'd1, 5'd2, 32'd1, 32'd2, 16'hFFFF, 1'b1);
    cyc();
    check("imm_zero", data_2, 32'h0000FFFF);
    idle(); cyc();

    // Backpressure: three attempts, two land, third waits
    out_ready = 1'b0;
    drive(5'd1, 5'd3, 5'd3, 5'd0, 5'd0, 32'd100, 32'd101, 16'h0, 1'b0);
    cyc();
    check("bp_ready_after_1", in_ready, 1'b1);
    drive(5'd2, 5'd4, 5'd4, 5'd0, 5'd0, 32'd200, 32'd201, 16'h0, 1'b0);
    cyc();
    check("bp_ready_after_2", in_ready, 1'b0);
    check("bp_hold_a", data_1, 32'd100);
    drive(5'd3, 5'd5, 5'd5, 5'd0, 5'd0, 32'd300, 32'd301, 16'h0, 1'b0);
    cyc();
    check("bp_hold_b", data_1, 32'd100);
    cyc();
    check("bp_hold_c", {op, data_1}, {5'd1, 32'd100});
    out_ready = 1'b1;
    cyc();
    check("bp_second", data_1, 32'd200);
    cyc();
    check("bp_third", data_1, 32'd300);
    idle(); cyc();
    check("bp_drained", out_valid, 1'b0);

    // Reset while FULL
    out_ready = 1'b0;
    drive(5'd4, 5'd0, 5'd6, 5'd0, 5'd0, 32'd400, 32'd401, 16'h0, 1'b0);
    cyc();
    drive(5'd5, 5'd0, 5'd7, 5'd0, 5'd0, 32'd500, 32'd501, 16'h0, 1'b0);
    cyc(); idle();
    check("full_before_rst", {out_valid, in_ready}, 2'b10);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_ready", in_ready, 1'b1);
    check("rst_mid_data", {data_1, out_rd_addr}, '0);
    cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      cyc();
      check("rst_no_stale", out_valid, 1'b0);
    end

    // Streaming: accept and drain every cycle
    for (int unsigned i = 0; i < 8; i++) begin
      drive(5'(i), 5'(i), 5'(i), 5'd0, 5'd0, 32'(1000 + i), 32'(2000 + i),
            16'h8000 | 16'(i), 1'(i % 2));
      cyc();
      check("stream_valid", out_valid, 1'b1);
      check("stream_data_1", data_1, 32'(1000 + i));
    end
    idle(); cyc();
    check("stream_end", out_valid, 1'b0);

`ifdef ALU_OPERAND_FORWARD_EN
    // Capture-time forwarding on rs
    fwd_valid = 1'b1; fwd_addr = 5'd3; fwd_data = 32'd42;
    drive(5'd0, 5'd0, 5'd8, 5'd3, 5'd5, 32'd1, 32'd2, 16'h0, 1'b0);
    cyc(); idle(); fwd_valid = 1'b0;
    check("fwd_capture_d1", data_1, 32'd42);
    check("fwd_capture_d2", data_2, 32'd2);
    cyc();

    // Held entry patched on rt
    out_ready = 1'b0;
    drive(5'd0, 5'd0, 5'd9, 5'd6, 5'd4, 32'd1, 32'd1, 16'h0, 1'b0);
    cyc(); idle();
    check("fwd_held_before", data_2, 32'd1);
    fwd_valid = 1'b1; fwd_addr = 5'd4; fwd_data = 32'd9;
    cyc(); fwd_valid = 1'b0;
    check("fwd_held_after", data_2, 32'd9);
    out_ready = 1'b1;
    cyc();

    // Register zero is never forwarded
    fwd_valid = 1'b1; fwd_addr = 5'd0; fwd_data = 32'd77;
    drive(5'd0, 5'd0, 5'd10, 5'd0, 5'd0, 32'd11, 32'd12, 16'h0, 1'b0);
    cyc(); idle(); fwd_valid = 1'b0;
    check("fwd_zero", {data_1, data_2}, {32'd11, 32'd12});
    cyc();
`else
    // Forwarding ports have no effect in this build
    fwd_valid = 1'b1; fwd_addr = 5'd3; fwd_data = 32'd42;
    drive(5'd0, 5'd0, 5'd8, 5'd3, 5'd3, 32'd1, 32'd2, 16'h0, 1'b0);
    cyc(); idle(); fwd_valid = 1'b0;
    check("fwd_ignored", {data_1, data_2}, {32'd1, 32'd2});
    cyc();
`endif

    repeat (2) cyc();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
